// File: rtl/dp_pkg.sv
// Shared encodings for the sequenced datapath: opcodes, shifter modes, sequencer states.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package dp_pkg;

   // Instruction opcodes; both 110 and 111 decode as NOP.
   typedef enum logic [2:0] {
      OP_MOVI = 3'b000,
      OP_MOVR = 3'b001,
      OP_ADD  = 3'b010,
      OP_CMP  = 3'b011,
      OP_AND  = 3'b100,
      OP_MVN  = 3'b101,
      OP_NOP0 = 3'b110,
      OP_NOP1 = 3'b111
   } op_e;

   // B-operand shifter modes
   typedef enum logic [1:0] {
      SH_NONE = 2'b00,
      SH_LSL1 = 2'b01,
      SH_LSR1 = 2'b10,
      SH_ASR1 = 2'b11
   } shift_e;

   // Micro-sequencer states
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LDA  = 3'd1,
      S_LDB  = 3'd2,
      S_EXEC = 3'd3,
      S_WB   = 3'd4
   } state_e;

   // NOP needs no datapath work and completes straight from IDLE
   function automatic logic is_nop(input op_e op);
      return (op == OP_NOP0) || (op == OP_NOP1);
   endfunction

   // Ops that read the A operand through the LDA step
   function automatic logic uses_a(input op_e op);
      return (op == OP_ADD) || (op == OP_CMP) || (op == OP_AND);
   endfunction

endpackage

// File: rtl/dp_regfile.sv
// Register file: NREG x W, one synchronous write port, two combinational reads plus a debug read.
// Latency: reads are combinational; a write is visible after the writing edge.
// Backpressure: none; a write is accepted every cycle we is high.
module dp_regfile #(
   parameter  int W    = 16,
   parameter  int NREG = 8,
   localparam int RW   = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [RW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [RW-1:0] raddr_a,
   output logic [W-1:0]  rdata_a,
   input  logic [RW-1:0] raddr_b,
   output logic [W-1:0]  rdata_b,
   input  logic [RW-1:0] dbg_sel,
   output logic [W-1:0]  dbg_data
);

   logic [W-1:0] mem_q [NREG];

   // Storage: cleared by reset, otherwise a single write per cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Read ports are plain muxes so the sequencer can load A/B in the same cycle it addresses them
   always_comb begin
      rdata_a  = mem_q[raddr_a];
      rdata_b  = mem_q[raddr_b];
      dbg_data = mem_q[dbg_sel];
   end

endmodule

// File: rtl/dp_seq_core.sv
// Sequenced datapath: register file, one-bit shifter, ALU, A/B/C/flag registers under a micro-sequencer.
// Latency: start edge k -> done after k+4 (ADD/AND), k+3 (MOVR/MVN/CMP), k+1 (MOVI), k (NOP).
// Backpressure: start is only sampled in IDLE; starts while busy are dropped, busy tells the caller.
module dp_seq_core
   import dp_pkg::*;
#(
   parameter  int W    = 16,
   parameter  int NREG = 8,
   localparam int RW   = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [2:0]    op,
   input  logic [RW-1:0] rd,
   input  logic [RW-1:0] rn,
   input  logic [RW-1:0] rm,
   input  logic [1:0]    shift,
   input  logic [W-1:0]  imm,
   output logic          busy,
   output logic          done,
   output logic [W-1:0]  datapath_out,
   output logic          Z_out,
   output logic          N_out,
   output logic          V_out,
   input  logic [RW-1:0] dbg_sel,
   output logic [W-1:0]  dbg_data
);

   // Sequencer state
   state_e state_q, state_d;

   // Latched instruction fields
   op_e           op_q;
   shift_e        sh_q;
   logic [RW-1:0] rd_q, rn_q, rm_q;
   logic [W-1:0]  imm_q;

   // Datapath registers
   logic [W-1:0]  a_q, b_q, c_q;
   logic          z_q, n_q, v_q;
   logic          done_q, done_d;

   // Sequencer control strobes
   logic          cap_en, ld_a, ld_b, ex_en, wb_en;

   // Register file connections
   logic [W-1:0]  rdata_a, rdata_b, wb_data;

   // ALU signals
   logic [W-1:0]  ain, bs, res;
   logic          v_res;

   op_e           op_in;
   assign op_in = op_e'(op);

   // One-bit shifter on the B operand
   function automatic logic [W-1:0] shift_b(input logic [W-1:0] b, input shift_e sh);
      logic [W-1:0] r;
      case (sh)
         SH_LSL1: r = {b[W-2:0], 1'b0};
         SH_LSR1: r = {1'b0, b[W-1:1]};
         SH_ASR1: r = {b[W-1], b[W-1:1]};
         default: r = b;
      endcase
      return r;
   endfunction

   dp_regfile #(
      .W    (W),
      .NREG (NREG)
   ) u_regfile (
      .clk      (clk),
      .reset    (reset),
      .we       (wb_en),
      .waddr    (rd_q),
      .wdata    (wb_data),
      .raddr_a  (rn_q),
      .rdata_a  (rdata_a),
      .raddr_b  (rm_q),
      .rdata_b  (rdata_b),
      .dbg_sel  (dbg_sel),
      .dbg_data (dbg_data)
   );

   // Sequencer state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: IDLE dispatches on the incoming op, later states on the latched op
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (op_in == OP_MOVI) begin
                  state_d = S_WB;
               end else if ((op_in == OP_MOVR) || (op_in == OP_MVN)) begin
                  state_d = S_LDB;
               end else if (uses_a(op_in)) begin
                  state_d = S_LDA;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_LDA:   state_d = S_LDB;
         S_LDB:   state_d = S_EXEC;
         S_EXEC:  state_d = (op_q == OP_CMP) ? S_IDLE : S_WB;
         S_WB:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Sequencer outputs: per-state strobes and the completion condition feeding the done register
   always_comb begin
      busy   = (state_q != S_IDLE);
      cap_en = (state_q == S_IDLE) && start;
      ld_a   = (state_q == S_LDA);
      ld_b   = (state_q == S_LDB);
      ex_en  = (state_q == S_EXEC);
      wb_en  = (state_q == S_WB);
      done_d = (cap_en && is_nop(op_in))
             || (ex_en && (op_q == OP_CMP))
             || wb_en;
   end

   // Instruction capture; fields hold for the whole operation so inputs may change freely
   always_ff @(posedge clk) begin
      if (reset) begin
         op_q  <= OP_MOVI;
         sh_q  <= SH_NONE;
         rd_q  <= '0;
         rn_q  <= '0;
         rm_q  <= '0;
         imm_q <= '0;
      end else if (cap_en) begin
         op_q  <= op_in;
         sh_q  <= shift_e'(shift);
         rd_q  <= rd;
         rn_q  <= rn;
         rm_q  <= rm;
         imm_q <= imm;
      end
   end

   // Operand registers loaded in their dedicated steps
   always_ff @(posedge clk) begin
      if (reset) begin
         a_q <= '0;
         b_q <= '0;
      end else begin
         if (ld_a) a_q <= rdata_a;
         if (ld_b) b_q <= rdata_b;
      end
   end

   // ALU: MOVR/MVN ignore A so a stale A from an earlier op cannot leak in
   always_comb begin
      bs    = shift_b(b_q, sh_q);
      ain   = ((op_q == OP_MOVR) || (op_q == OP_MVN)) ? '0 : a_q;
      res   = '0;
      v_res = 1'b0;
      case (op_q)
         OP_ADD: begin
            res   = ain + bs;
            v_res = (ain[W-1] == bs[W-1]) && (res[W-1] != ain[W-1]);
         end
         OP_CMP: begin
            res   = ain - bs;
            v_res = (ain[W-1] != bs[W-1]) && (res[W-1] != ain[W-1]);
         end
         OP_AND:  res = ain & bs;
         OP_MVN:  res = ~bs;
         OP_MOVR: res = bs;
         default: res = '0;
      endcase
   end

   // Result and flags: flags follow every EXEC, C is untouched by CMP
   always_ff @(posedge clk) begin
      if (reset) begin
         c_q <= '0;
         z_q <= 1'b0;
         n_q <= 1'b0;
         v_q <= 1'b0;
      end else if (ex_en) begin
         z_q <= (res == '0);
         n_q <= res[W-1];
         v_q <= v_res;
         if (op_q != OP_CMP) c_q <= res;
      end
   end

   // Completion pulse, registered so it lands in the cycle after the final edge
   always_ff @(posedge clk) begin
      if (reset) begin
         done_q <= 1'b0;
      end else begin
         done_q <= done_d;
      end
   end

   assign wb_data      = (op_q == OP_MOVI) ? imm_q : c_q;
   assign done         = done_q;
   assign datapath_out = c_q;
   assign Z_out        = z_q;
   assign N_out        = n_q;
   assign V_out        = v_q;

endmodule

// File: doc/dp_seq_core.md
Name: dp_seq_core

Overview:
- Parametrised successor to the lab datapath: register file, barrel-lite shifter, ALU and A/B/C/status registers.
- Driven by an internal micro-sequencer rather than external loada/loadb/loadc/loads/vsel strobes.
- Accepts one three-operand instruction per start/done handshake and reports Z, N and V flags.
- Sits between the future instruction decoder and memory interface; replaces hand-sequenced datapath control.

Parameters:
- W, 16, datapath width in bits (W >= 4).
- NREG, 8, register count, power of two >= 2.
- RW, $clog2(NREG), register index width (derived, not overridden).

Ports:
- clk  in  1  clock, rising-edge active.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  3  000 MOVI, 001 MOVR, 010 ADD, 011 CMP, 100 AND, 101 MVN, 110/111 NOP.
- rd  in  RW  destination register.
- rn  in  RW  A-operand register.
- rm  in  RW  B-operand register (shifted).
- shift  in  2  00 none, 01 LSL1, 10 LSR1 (MSB<-0), 11 ASR1 (MSB kept).
- imm  in  W  immediate for MOVI.
- busy  out  1  high in any state other than IDLE.
- done  out  1  registered one-cycle completion pulse.
- datapath_out  out  W  C register.
- Z_out  out  1  result == 0.
- N_out  out  1  result[W-1].
- V_out  out  1  signed overflow.
- dbg_sel  in  RW  debug read select.
- dbg_data  out  W  combinational read of R[dbg_sel].

Behaviour:
- Reset: state IDLE; all R[i], A, B and C = 0; Z/N/V = 0; busy = 0; done = 0.
- Capture: in IDLE, start=1 at an edge latches op, rd, rn, rm, shift and imm. Inputs may change afterwards.
- States: IDLE, LDA, LDB, EXEC, WB.
- Transitions from IDLE on start:
  - MOVI -> WB.
  - MOVR/MVN -> LDB.
  - ADD/CMP/AND -> LDA.
  - NOP -> IDLE, with done pulsed.
- LDA: A <= R[rn]; -> LDB.
- LDB: B <= R[rm]; -> EXEC.
- EXEC:
  - Operand Bs = shift(B). MOVR/MVN use Ain = 0.
  - Result: ADD: A+Bs. CMP: A-Bs. AND: A&Bs. MVN: ~Bs. MOVR: Bs. All results are W bits, carry discarded.
  - Flags update on every EXEC.
  - V is two's-complement overflow for ADD and CMP; V = 0 otherwise.
  - C <= result for all ops except CMP, which leaves C unchanged.
  - Next state: CMP -> IDLE with done pulsed; all others -> WB.
- WB: R[rd] <= (MOVI ? latched imm : C); -> IDLE with done pulsed. MOVI leaves C and flags unchanged.
- done: asserted for the one cycle following the final edge.
- Latency, with the start edge as k, is the edge after which done is high:
  - ADD/AND: k+4.
  - MOVR/MVN/CMP: k+3.
  - MOVI: k+1.
  - NOP: k.
- start while busy, or in the cycle done is high-but-IDLE: ignored when busy. A start sampled in IDLE is accepted, even in the done cycle.
- rd equal to rn or rm is legal: reads complete before WB.
- Reset mid-operation overrides everything: next cycle is IDLE, all registers and flags are 0, and no done is issued.
- No latches; all storage is clk-edge.

Decomposition:
- Shared package dp_pkg holds the op encodings, shift encodings and state enum.
- One sub-module, dp_regfile (parametrised W, NREG, synchronous reset, one write port, two read ports plus debug read).
- Shifter and ALU are functions or always_comb blocks inside the core.

Test Plan (W=16, NREG=8 unless noted):
- MOVI R3,0x0042; MOVI R5,0x0013; ADD R2,R5,R3 -> R2=0x0055, datapath_out=0x0055, Z=0 N=0 V=0, done high after edge k+4 only.
- R0=0x7FFF, R1=0x0001; ADD R6,R0,R1 -> R6=0x8000, N=1 V=1 Z=0. Then CMP R1,R1 -> Z=1 N=0 V=0, datapath_out stays 0x8000, no register changes, done after k+3.
- R3=0x8004; MOVR R4,R3 with shift 11 -> 0xC002; shift 10 -> 0x4002; shift 01 -> 0x0008; shift 00 -> 0x8004.
- Assert start with a different op on every cycle while busy -> only the first executes, register contents match a single execution, and exactly one done pulse is seen.
- Reset asserted in EXEC of ADD -> next cycle busy=0 done=0, all dbg_data reads 0, flags 0. A following MOVI R7,0x1234 completes normally.
- W=8, NREG=16: MOVI R15,0xFF; MVN R14,R15 -> R14=0x00, Z=1 N=0. AND R13,R15,R15 with shift 11 -> 0xFF, N=1.
